// File: rtl/mano_serial_io_if.sv
// Processor-side FGI/FGO handshake and serial line signals of the basic-computer I/O peripheral.
interface mano_serial_io_if;
    logic [7:0] outr;
    logic       out_load;
    logic       fgo;
    logic [7:0] inpr;
    logic       inp_ack;
    logic       fgi;
    logic       txd;
    logic       rxd;
    logic       overrun;
    logic       frame_err;
    logic       io_req;

    modport master (
        output outr, out_load, inp_ack, rxd,
        input  fgo, inpr, fgi, txd, overrun, frame_err, io_req
    );

    modport slave (
        input  outr, out_load, inp_ack, rxd,
        output fgo, inpr, fgi, txd, overrun, frame_err, io_req
    );
endinterface

// File: rtl/mano_serial_io.sv
// 8N1 serial peripheral: drains OUTR to txd under FGO, assembles rxd into INPR under FGI.
module mano_serial_io #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input logic            clk,
    input logic            rst,
    mano_serial_io_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t        tx_state_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [2:0]       tx_bit_q;
    logic [7:0]       tx_shreg_q;
    logic             txd_q;
    logic             fgo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shreg_q <= '0;
            txd_q      <= 1'b1;
            fgo_q      <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (bus.out_load && fgo_q) begin
                        tx_shreg_q <= bus.outr;
                        fgo_q      <= 1'b0;
                        txd_q      <= 1'b0;
                        tx_cnt_q   <= '0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START, TX_DATA: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_state_q == TX_DATA && tx_bit_q == 3'd7) begin
                            txd_q      <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            // The shift register always holds the next bit to send in bit 0.
                            txd_q      <= tx_shreg_q[0];
                            tx_shreg_q <= {1'b0, tx_shreg_q[7:1]};
                            if (tx_state_q == TX_START) begin
                                tx_bit_q   <= '0;
                                tx_state_q <= TX_DATA;
                            end else begin
                                tx_bit_q <= tx_bit_q + 3'd1;
                            end
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_ONE;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        fgo_q      <= 1'b1;
                        tx_state_q <= TX_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_ONE;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    rx_state_t        rx_state_q;
    logic             rx_meta_q;
    logic             rxs_q;
    logic             rx_armed_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_shreg_q;
    logic [7:0]       inpr_q;
    logic             fgi_q;
    logic             overrun_q;
    logic             frame_err_q;

    // Synchronizer resets low so a line held low across reset never arms the receiver.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q  <= RX_IDLE;
            rx_meta_q   <= 1'b0;
            rxs_q       <= 1'b0;
            rx_armed_q  <= 1'b0;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shreg_q  <= '0;
            inpr_q      <= '0;
            fgi_q       <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q <= bus.rxd;
            rxs_q     <= rx_meta_q;
            if (bus.inp_ack && fgi_q) begin
                fgi_q     <= 1'b0;
                overrun_q <= 1'b0;
            end
            case (rx_state_q)
                RX_IDLE: begin
                    rx_cnt_q <= '0;
                    rx_bit_q <= '0;
                    if (!rxs_q && rx_armed_q) begin
                        rx_armed_q <= 1'b0;
                        rx_state_q <= RX_START;
                    end else if (rxs_q) begin
                        rx_armed_q <= 1'b1;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= rxs_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shreg_q <= {rxs_q, rx_shreg_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_IDLE;
                        // A coincident inp_ack frees INPR, so the new byte loads instead of overrunning.
                        if (!rxs_q) begin
                            frame_err_q <= 1'b1;
                        end else if (!fgi_q || bus.inp_ack) begin
                            inpr_q      <= rx_shreg_q;
                            fgi_q       <= 1'b1;
                            frame_err_q <= 1'b0;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign bus.fgo       = fgo_q;
    assign bus.txd       = txd_q;
    assign bus.inpr      = inpr_q;
    assign bus.fgi       = fgi_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;
    assign bus.io_req    = fgi_q | fgo_q;
endmodule

// File: tb/tb_mano_serial_io.sv
// Bench for mano_serial_io: scoreboarded TX/RX characters, vector table, and handshake corner cases.
module tb_mano_serial_io;
    localparam int unsigned CPB = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mano_serial_io_if bus ();

    mano_serial_io #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [7:0]  tx_exp_q[$];
    logic [7:0]  rx_exp_q[$];
    bit          tx_mon_en = 1'b1;
    int unsigned rx_lat;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        logic       rx_stop;
        logic [7:0] exp_inpr;
        logic       exp_fgi;
        logic       exp_ferr;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Frame starts 1 time unit after the next rising edge; returns 1 unit after edge 160.
    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            bus.rxd = f[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        bus.rxd = 1'b1;
    endtask

    task automatic ack();
        @(negedge clk); bus.inp_ack = 1'b1;
        @(negedge clk); bus.inp_ack = 1'b0;
    endtask

    task automatic load_tx(input logic [7:0] d);
        @(negedge clk);
        bus.outr = d; bus.out_load = 1'b1;
        tx_exp_q.push_back(d);
        @(negedge clk);
        bus.out_load = 1'b0;
    endtask

    task automatic wait_fgo(input string name);
        int unsigned k;
        k = 0;
        while (!bus.fgo && k < 400) begin
            @(negedge clk);
            k++;
        end
        check(name, bus.fgo, 1);
    endtask

    // TX monitor: decodes txd at mid-bit and pops the scoreboard.
    initial begin : tx_mon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx_mon_en && !rst && bus.txd == 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = bus.txd;
                end
                repeat (CPB) @(negedge clk);
                check("tx_stop_bit", bus.txd, 1);
                if (tx_exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL tx_unexpected_frame: got 0x%0h, expected no frame", b);
                end else begin
                    check("tx_char", b, tx_exp_q.pop_front());
                end
            end
        end
    end

    // RX monitor: every rising fgi must deliver the next expected character.
    initial begin : rx_mon
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (bus.fgi && !prev) begin
                    if (rx_exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL rx_unexpected_char: got 0x%0h, expected none", bus.inpr);
                    end else begin
                        check("rx_char", bus.inpr, rx_exp_q.pop_front());
                    end
                end
                prev = bus.fgi;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [9:0]  fr;
        int unsigned low_cnt;

        vecs[0] = '{8'h53, 8'hE9, 1'b1, 8'hE9, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'hA5, 8'h3C, 1'b0, 8'hFF, 1'b0, 1'b1};
        vecs[4] = '{8'h5A, 8'hC3, 1'b1, 8'hC3, 1'b1, 1'b0};

        bus.outr = '0; bus.out_load = 1'b0; bus.inp_ack = 1'b0; bus.rxd = 1'b1;
        rst = 1'b1;
        tick(2);
        check("rst_fgo", bus.fgo, 1);
        check("rst_fgi", bus.fgi, 0);
        check("rst_inpr", bus.inpr, 8'h00);
        check("rst_txd", bus.txd, 1);
        check("rst_overrun", bus.overrun, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_io_req", bus.io_req, 1);
        rst = 1'b0;
        tick(5);

        // 0x53 waveform, with an ignored 0xFF load 40 cycles in.
        fr = {1'b1, 8'h53, 1'b0};
        @(negedge clk);
        bus.outr = 8'h53; bus.out_load = 1'b1;
        tx_exp_q.push_back(8'h53);
        low_cnt = 0;
        for (int j = 0; j <= 160; j++) begin
            @(negedge clk);
            if (j == 0) bus.out_load = 1'b0;
            if (!bus.fgo) low_cnt++;
            if (j < 160 && (j % 16 == 0 || j % 16 == 15))
                check($sformatf("tx53_bit%0d_cyc%0d", j / 16, j), bus.txd, fr[j / 16]);
            if (j == 39) begin bus.outr = 8'hFF; bus.out_load = 1'b1; end
            if (j == 40) begin bus.out_load = 1'b0; bus.outr = 8'h53; end
        end
        check("tx53_fgo_after_160", bus.fgo, 1);
        check("tx53_fgo_low_cycles", low_cnt, 160);
        check("tx53_txd_idle", bus.txd, 1);
        tick(10);

        // 0xE9 receive with latency measurement.
        rx_exp_q.push_back(8'hE9);
        rx_lat = 0;
        fork
            send_rx(8'hE9, 1'b1);
            begin
                @(posedge clk);
                for (int k = 1; k <= 300; k++) begin
                    @(negedge clk);
                    if (bus.fgi) begin rx_lat = k; break; end
                end
            end
        join
        check("rxE9_latency_in_153_156", (rx_lat >= 153 && rx_lat <= 156), 1);
        check("rxE9_fgi", bus.fgi, 1);
        check("rxE9_inpr", bus.inpr, 8'hE9);
        ack();
        check("rxE9_ack_fgi", bus.fgi, 0);
        check("rxE9_ack_inpr", bus.inpr, 8'hE9);
        tick(20);

        // Overrun: 0x17 arrives while 0x83 is unread.
        rx_exp_q.push_back(8'h83);
        send_rx(8'h83, 1'b1);
        tick(20);
        send_rx(8'h17, 1'b1);
        check("ovr_inpr", bus.inpr, 8'h83);
        check("ovr_flag", bus.overrun, 1);
        check("ovr_fgi", bus.fgi, 1);
        ack();
        check("ovr_ack_fgi", bus.fgi, 0);
        check("ovr_ack_overrun", bus.overrun, 0);
        tick(20);

        // inp_ack in the exact cycle the 0x17 stop bit is sampled (edge 155 of the frame).
        rx_exp_q.push_back(8'h83);
        send_rx(8'h83, 1'b1);
        tick(20);
        fork
            send_rx(8'h17, 1'b1);
            begin
                @(posedge clk);
                repeat (154) @(posedge clk);
                #1 bus.inp_ack = 1'b1;
                @(posedge clk);
                #1 bus.inp_ack = 1'b0;
            end
        join
        check("coin_inpr", bus.inpr, 8'h17);
        check("coin_fgi", bus.fgi, 1);
        check("coin_overrun", bus.overrun, 0);
        ack();
        check("coin_ack_fgi", bus.fgi, 0);
        tick(20);

        // 3-cycle low glitch.
        @(negedge clk); bus.rxd = 1'b0;
        tick(3);
        bus.rxd = 1'b1;
        tick(200);
        check("glitch_fgi", bus.fgi, 0);
        check("glitch_inpr", bus.inpr, 8'h17);
        check("glitch_frame_err", bus.frame_err, 0);
        check("glitch_overrun", bus.overrun, 0);

        // Simultaneous out_load and inp_ack.
        rx_exp_q.push_back(8'h42);
        send_rx(8'h42, 1'b1);
        tick(2);
        @(negedge clk);
        bus.outr = 8'h99; bus.out_load = 1'b1; bus.inp_ack = 1'b1;
        tx_exp_q.push_back(8'h99);
        @(negedge clk);
        bus.out_load = 1'b0; bus.inp_ack = 1'b0;
        check("sim_fgo", bus.fgo, 0);
        check("sim_fgi", bus.fgi, 0);
        check("sim_txd_start", bus.txd, 0);
        check("sim_io_req", bus.io_req, 0);
        wait_fgo("sim_tx_done");
        tick(20);

        // Vector table: concurrent TX and RX characters.
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].rx_stop) rx_exp_q.push_back(vecs[i].rx);
            fork
                load_tx(vecs[i].tx);
                send_rx(vecs[i].rx, vecs[i].rx_stop);
            join
            wait_fgo($sformatf("vec%0d_fgo", i));
            check($sformatf("vec%0d_fgi", i), bus.fgi, vecs[i].exp_fgi);
            check($sformatf("vec%0d_inpr", i), bus.inpr, vecs[i].exp_inpr);
            check($sformatf("vec%0d_frame_err", i), bus.frame_err, vecs[i].exp_ferr);
            check($sformatf("vec%0d_io_req", i), bus.io_req, 1);
            if (vecs[i].exp_fgi) ack();
            check($sformatf("vec%0d_fgi_clear", i), bus.fgi, 0);
            tick(20);
        end

        tick(20);
        check("tx_scoreboard_empty", tx_exp_q.size(), 0);
        check("rx_scoreboard_empty", rx_exp_q.size(), 0);

        // Reset in the middle of a TX frame.
        tx_mon_en = 1'b0;
        @(negedge clk);
        bus.outr = 8'h00; bus.out_load = 1'b1;
        @(negedge clk);
        bus.out_load = 1'b0;
        tick(50);
        check("txrst_busy_fgo", bus.fgo, 0);
        rst = 1'b1;
        #1;
        check("txrst_txd_immediate", bus.txd, 1);
        check("txrst_fgo_immediate", bus.fgo, 1);
        check("txrst_io_req", bus.io_req, 1);
        tick(2);
        rst = 1'b0;
        tick(20);
        check("txrst_txd_after", bus.txd, 1);
        check("txrst_fgo_after", bus.fgo, 1);
        check("txrst_fgi_after", bus.fgi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
